// File: rtl/ahblite_slave_mux.sv
// Data-phase response mux for a 6-port AHB-Lite slave fabric, with a built-in
// default slave that answers unmapped active transfers with a two-cycle ERROR.
module ahblite_slave_mux #(
   parameter logic [5:0]  PORT_EN       = 6'b111111,
   parameter logic [31:0] DEFAULT_RDATA = 32'h0
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HREADY,
   input  logic [1:0]  HTRANS,
   input  logic        P0_HSEL,
   input  logic        P1_HSEL,
   input  logic        P2_HSEL,
   input  logic        P3_HSEL,
   input  logic        P4_HSEL,
   input  logic        P5_HSEL,
   input  logic [31:0] P0_HRDATA,
   input  logic [31:0] P1_HRDATA,
   input  logic [31:0] P2_HRDATA,
   input  logic [31:0] P3_HRDATA,
   input  logic [31:0] P4_HRDATA,
   input  logic [31:0] P5_HRDATA,
   input  logic        P0_HREADYOUT,
   input  logic        P1_HREADYOUT,
   input  logic        P2_HREADYOUT,
   input  logic        P3_HREADYOUT,
   input  logic        P4_HREADYOUT,
   input  logic        P5_HREADYOUT,
   input  logic        P0_HRESP,
   input  logic        P1_HRESP,
   input  logic        P2_HRESP,
   input  logic        P3_HRESP,
   input  logic        P4_HRESP,
   input  logic        P5_HRESP,
   output logic [31:0] HRDATA,
   output logic        HREADY_OUT,
   output logic        HRESP,
   output logic [1:0]  dbg_state_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ERR1 = 2'd1;
   localparam logic [1:0] ST_ERR2 = 2'd2;

   logic [5:0]  hsel_en;
   logic [5:0]  hsel_oh;
   logic        unmapped_active;
   logic [6:0]  sel_d, sel_q;
   logic [1:0]  state_d, state_q;
   logic [31:0] p_rdata [6];
   logic [5:0]  p_ready;
   logic [5:0]  p_resp;
   logic        unused_htrans0;

   assign unused_htrans0 = HTRANS[0];

   assign p_rdata[0] = P0_HRDATA;
   assign p_rdata[1] = P1_HRDATA;
   assign p_rdata[2] = P2_HRDATA;
   assign p_rdata[3] = P3_HRDATA;
   assign p_rdata[4] = P4_HRDATA;
   assign p_rdata[5] = P5_HRDATA;
   assign p_ready = {P5_HREADYOUT, P4_HREADYOUT, P3_HREADYOUT,
                     P2_HREADYOUT, P1_HREADYOUT, P0_HREADYOUT};
   assign p_resp  = {P5_HRESP, P4_HRESP, P3_HRESP, P2_HRESP, P1_HRESP, P0_HRESP};

   // x & -x isolates the lowest set bit, so the lowest-index port wins.
   assign hsel_en = {P5_HSEL, P4_HSEL, P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL} & PORT_EN;
   assign hsel_oh = hsel_en & (~hsel_en + 6'd1);
   assign unmapped_active = HTRANS[1] & ~|hsel_en;

   assign sel_d = HREADY ? {unmapped_active, hsel_oh} : sel_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (HREADY && unmapped_active) state_d = ST_ERR1;
         ST_ERR1: state_d = ST_ERR2;
         ST_ERR2: state_d = (HREADY && unmapped_active) ? ST_ERR1 : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         sel_q   <= 7'd0;
         state_q <= ST_IDLE;
      end else begin
         sel_q   <= sel_d;
         state_q <= state_d;
      end
   end

   // sel_q is one-hot or zero, so at most one branch below fires.
   always_comb begin
      HRDATA     = DEFAULT_RDATA;
      HREADY_OUT = 1'b1;
      HRESP      = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (sel_q[i]) begin
            HRDATA     = p_rdata[i];
            HREADY_OUT = p_ready[i];
            HRESP      = p_resp[i];
         end
      end
      if (sel_q[6]) begin
         HREADY_OUT = (state_q != ST_ERR1);
         HRESP      = (state_q == ST_ERR1) || (state_q == ST_ERR2);
      end
   end

   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Bench for ahblite_slave_mux: a full-map instance and a masked instance share
// stimulus; a data-phase ownership model predicts every output each cycle.
module tb_ahblite_slave_mux;

   localparam logic [5:0]  EN_B  = 6'b111011;
   localparam logic [31:0] DEF_B = 32'hE5E5_0001;

   logic        clk = 1'b0;
   logic        hreset;
   logic [1:0]  htrans;
   logic [5:0]  hsel;
   logic [31:0] prdata [6];
   logic [5:0]  preadyout;
   logic [5:0]  presp;

   logic [31:0] rdata_a, rdata_b;
   logic        ready_a, ready_b, resp_a, resp_b;
   logic [1:0]  dbg_a, dbg_b;

   int vectors = 0;
   int miscompares = 0;

   // Data-phase owner: -1 none, 0..5 port, 6 default slave; err_ph is 1 or 2.
   int owner [2];
   int err_ph [2];

   always #5 clk = ~clk;

   ahblite_slave_mux dut_a (
      .HCLK(clk), .HRESET(hreset), .HREADY(ready_a), .HTRANS(htrans),
      .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]),
      .P3_HSEL(hsel[3]), .P4_HSEL(hsel[4]), .P5_HSEL(hsel[5]),
      .P0_HRDATA(prdata[0]), .P1_HRDATA(prdata[1]), .P2_HRDATA(prdata[2]),
      .P3_HRDATA(prdata[3]), .P4_HRDATA(prdata[4]), .P5_HRDATA(prdata[5]),
      .P0_HREADYOUT(preadyout[0]), .P1_HREADYOUT(preadyout[1]), .P2_HREADYOUT(preadyout[2]),
      .P3_HREADYOUT(preadyout[3]), .P4_HREADYOUT(preadyout[4]), .P5_HREADYOUT(preadyout[5]),
      .P0_HRESP(presp[0]), .P1_HRESP(presp[1]), .P2_HRESP(presp[2]),
      .P3_HRESP(presp[3]), .P4_HRESP(presp[4]), .P5_HRESP(presp[5]),
      .HRDATA(rdata_a), .HREADY_OUT(ready_a), .HRESP(resp_a), .dbg_state_o(dbg_a)
   );

   ahblite_slave_mux #(.PORT_EN(EN_B), .DEFAULT_RDATA(DEF_B)) dut_b (
      .HCLK(clk), .HRESET(hreset), .HREADY(ready_b), .HTRANS(htrans),
      .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]),
      .P3_HSEL(hsel[3]), .P4_HSEL(hsel[4]), .P5_HSEL(hsel[5]),
      .P0_HRDATA(prdata[0]), .P1_HRDATA(prdata[1]), .P2_HRDATA(prdata[2]),
      .P3_HRDATA(prdata[3]), .P4_HRDATA(prdata[4]), .P5_HRDATA(prdata[5]),
      .P0_HREADYOUT(preadyout[0]), .P1_HREADYOUT(preadyout[1]), .P2_HREADYOUT(preadyout[2]),
      .P3_HREADYOUT(preadyout[3]), .P4_HREADYOUT(preadyout[4]), .P5_HREADYOUT(preadyout[5]),
      .P0_HRESP(presp[0]), .P1_HRESP(presp[1]), .P2_HRESP(presp[2]),
      .P3_HRESP(presp[3]), .P4_HRESP(presp[4]), .P5_HRESP(presp[5]),
      .HRDATA(rdata_b), .HREADY_OUT(ready_b), .HRESP(resp_b), .dbg_state_o(dbg_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_out(input int k, output logic [31:0] r, output logic rdy, output logic rs);
      logic [31:0] def;
      def = (k == 0) ? 32'h0 : DEF_B;
      if (owner[k] >= 0 && owner[k] < 6) begin
         r   = prdata[owner[k]];
         rdy = preadyout[owner[k]];
         rs  = presp[owner[k]];
      end else if (owner[k] == 6) begin
         r   = def;
         rdy = (err_ph[k] == 2);
         rs  = 1'b1;
      end else begin
         r   = def;
         rdy = 1'b1;
         rs  = 1'b0;
      end
   endtask

   task automatic model_edge(input int k, input logic rdy);
      logic [5:0] m;
      int lo;
      m  = hsel & ((k == 0) ? 6'b111111 : EN_B);
      lo = -1;
      for (int i = 5; i >= 0; i--) if (m[i]) lo = i;
      if (hreset) begin
         owner[k]  = -1;
         err_ph[k] = 0;
      end else if (rdy) begin
         if (lo >= 0) owner[k] = lo;
         else if (htrans[1]) begin
            owner[k]  = 6;
            err_ph[k] = 1;
         end else owner[k] = -1;
      end else if (owner[k] == 6 && err_ph[k] == 1) begin
         err_ph[k] = 2;
      end
   endtask

   // Check both instances against the model, then advance one clock.
   task automatic cycle();
      logic [31:0] er;
      logic erdy, ers;
      logic rdy_now [2];
      #1;
      model_out(0, er, erdy, ers);
      rdy_now[0] = erdy;
      chk("a_hrdata", rdata_a, er);
      chk("a_hready", {31'd0, ready_a}, {31'd0, erdy});
      chk("a_hresp", {31'd0, resp_a}, {31'd0, ers});
      model_out(1, er, erdy, ers);
      rdy_now[1] = erdy;
      chk("b_hrdata", rdata_b, er);
      chk("b_hready", {31'd0, ready_b}, {31'd0, erdy});
      chk("b_hresp", {31'd0, resp_b}, {31'd0, ers});
      @(posedge clk);
      model_edge(0, rdy_now[0]);
      model_edge(1, rdy_now[1]);
      @(negedge clk);
   endtask

   task automatic idle_bus();
      hsel   = 6'd0;
      htrans = 2'b00;
   endtask

   initial begin
      hreset    = 1'b1;
      htrans    = 2'b00;
      hsel      = 6'd0;
      preadyout = 6'b111111;
      presp     = 6'd0;
      for (int i = 0; i < 6; i++) prdata[i] = 32'h1000_0000 + i;
      repeat (2) @(posedge clk);
      @(negedge clk);
      owner[0] = -1; owner[1] = -1; err_ph[0] = 0; err_ph[1] = 0;

      // Reset release with all inputs idle
      for (int i = 0; i < 6; i++) prdata[i] = 32'h0;
      cycle();
      hreset = 1'b0;
      #1;
      chk("t1_hrdata", rdata_a, 32'h0);
      chk("t1_hready", {31'd0, ready_a}, 32'd1);
      chk("t1_hresp", {31'd0, resp_a}, 32'd0);
      chk("t1_fsm_a", {30'd0, dbg_a}, 32'd0);
      chk("t1_fsm_b", {30'd0, dbg_b}, 32'd0);
      cycle();

      // Simple read from P1
      hsel = 6'b000010; htrans = 2'b10;
      cycle();
      idle_bus();
      prdata[1] = 32'hDEAD_BEEF;
      #1;
      chk("t2_hrdata", rdata_a, 32'hDEAD_BEEF);
      chk("t2_hready", {31'd0, ready_a}, 32'd1);
      chk("t2_hresp", {31'd0, resp_a}, 32'd0);
      cycle();

      // P3 inserts two wait states while P0 is presented
      hsel = 6'b001000; htrans = 2'b10;
      cycle();
      hsel = 6'b000001;
      preadyout[3] = 1'b0;
      #1 chk("t3_wait1", {31'd0, ready_a}, 32'd0);
      cycle();
      #1 chk("t3_wait2", {31'd0, ready_a}, 32'd0);
      cycle();
      preadyout[3] = 1'b1;
      #1 chk("t3_p3_done", {31'd0, ready_a}, 32'd1);
      cycle();
      idle_bus();
      prdata[0] = 32'h0000_A0A0;
      #1 chk("t3_p0_owns", rdata_a, 32'h0000_A0A0);
      cycle();

      // Unmapped NONSEQ -> two-cycle ERROR; then IDLE with no select -> OKAY
      hsel = 6'd0; htrans = 2'b10;
      cycle();
      idle_bus();
      #1 chk("t4_err1_rdy", {31'd0, ready_a}, 32'd0);
      chk("t4_err1_rsp", {31'd0, resp_a}, 32'd1);
      cycle();
      #1 chk("t4_err2_rdy", {31'd0, ready_a}, 32'd1);
      chk("t4_err2_rsp", {31'd0, resp_a}, 32'd1);
      cycle();
      #1 chk("t4_okay_rsp", {31'd0, resp_a}, 32'd0);
      cycle();
      cycle();
      #1 chk("t4_idle_rdy", {31'd0, ready_a}, 32'd1);
      chk("t4_idle_rsp", {31'd0, resp_a}, 32'd0);
      cycle();

      // Multiple selects and a masked port
      hsel = 6'b010100; htrans = 2'b10;
      cycle();
      idle_bus();
      prdata[2] = 32'h2222_2222;
      prdata[4] = 32'h4444_4444;
      #1 chk("t5_lowest_a", rdata_a, 32'h2222_2222);
      chk("t5_masked_b", rdata_b, 32'h4444_4444);
      cycle();
      hsel = 6'b000100; htrans = 2'b11;
      cycle();
      idle_bus();
      #1 chk("t5_b_err1_rdy", {31'd0, ready_b}, 32'd0);
      chk("t5_b_err1_rsp", {31'd0, resp_b}, 32'd1);
      chk("t5_b_rdata", rdata_b, DEF_B);
      cycle();
      #1 chk("t5_b_err2_rsp", {31'd0, resp_b}, 32'd1);
      cycle();
      #1 chk("t5_b_okay", {31'd0, resp_b}, 32'd0);
      cycle();

      // Reset while in ERR1
      hsel = 6'd0; htrans = 2'b10;
      cycle();
      idle_bus();
      hreset = 1'b1;
      #1 chk("t6_in_err1", {31'd0, ready_a}, 32'd0);
      cycle();
      hreset = 1'b0;
      #1 chk("t6_rdy", {31'd0, ready_a}, 32'd1);
      chk("t6_rsp", {31'd0, resp_a}, 32'd0);
      chk("t6_fsm", {30'd0, dbg_a}, 32'd0);
      cycle();

      // Randomized traffic against the model
      for (int n = 0; n < 800; n++) begin
         int r;
         hreset = ($urandom_range(0, 49) == 0);
         htrans = 2'($urandom_range(0, 3));
         r = $urandom_range(0, 9);
         if (r < 3) hsel = 6'd0;
         else if (r < 8) hsel = 6'd1 << $urandom_range(0, 5);
         else hsel = 6'($urandom_range(0, 63));
         for (int i = 0; i < 6; i++) begin
            preadyout[i] = ($urandom_range(0, 3) != 0);
            presp[i]     = ($urandom_range(0, 7) == 0);
            prdata[i]    = $urandom;
         end
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
